// File: rtl/vic_pkg.sv
// vic_pkg: shared FSM state type and default spurious vector for the interrupt controller
package vic_pkg;
    typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;
    localparam logic [15:0] SPUR_DEF = 16'o000000;
endpackage

// File: rtl/vic_arb.sv
// vic_arb: combinational winner search, descending from a start index with wrap-around
module vic_arb #(
    parameter int N = 2,
    parameter int RR = 0,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_elig,
    input  logic [IW-1:0] i_start,
    output logic [IW-1:0] o_idx,
    output logic          o_vld
);
    int w_s;
    // fixed priority always begins the search at the top channel
    assign w_s = (RR != 0) ? int'(i_start) : N - 1;
    always_comb begin
        o_vld = 1'b0;
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_elig[(w_s + N - i) % N]) begin
                o_vld = 1'b1;
                o_idx = IW'((w_s + N - i) % N);
            end
        end
    end
endmodule

// File: rtl/vic_prio.sv
// vic_prio: prioritised vectored interrupt controller with a strobe/ack vector read
// Edge channels latch pending on a rising request; level channels follow the request.
module vic_prio
    import vic_pkg::*;
#(
    parameter int            N        = 2,
    parameter logic [N-1:0]  EDGE     = '1,
    parameter int            RR       = 0,
    parameter logic [15:0]   SPUR_VEC = SPUR_DEF
) (
    input  logic            clk_sys,
    input  logic            wb_rst_i,
    input  logic            ce,
    input  logic [N-1:0]    ireq,
    input  logic [N-1:0]    imask,
    input  logic [16*N-1:0] ivec,
    input  logic            wb_stb_i,
    output logic            wb_ack_o,
    output logic [15:0]     wb_dat_o,
    output logic            wb_irq_o,
    output logic [N-1:0]    iack
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] TOP = IW'(N - 1);
    localparam logic [N-1:0] ONE = N'(1);

    state_t r_state, w_next;
    logic [N-1:0] r_pend, r_prev, r_oh, r_iack;
    logic [N-1:0] w_elig, w_rise, w_clr, w_oh, w_excl, w_pend;
    logic [IW-1:0] r_last, w_start, w_idx;
    logic [15:0] r_dat;
    logic r_ack, r_irq, w_vld, w_go;

    assign w_elig  = r_pend & ~imask;
    assign w_rise  = ireq & ~r_prev;
    assign w_go    = (r_state == IDLE) && wb_stb_i;
    assign w_oh    = w_vld ? ONE << w_idx : '0;
    assign w_clr   = w_go ? (w_oh & EDGE) : '0;
    // a fresh edge in the clearing cycle keeps the channel pending
    assign w_pend  = (EDGE & (w_rise | (r_pend & ~w_clr))) | (~EDGE & ireq);
    assign w_excl  = (r_state == IDLE) ? (w_go ? w_oh : '0) : r_oh;
    assign w_start = (r_last == '0) ? TOP : r_last - 1'b1;

    vic_arb #(.N(N), .RR(RR)) u_arb (
        .i_elig (w_elig),
        .i_start(w_start),
        .o_idx  (w_idx),
        .o_vld  (w_vld)
    );

    always_comb begin
        w_next = r_state;
        if (ce) begin
            case (r_state)
                IDLE:    w_next = wb_stb_i ? ACK : IDLE;
                ACK:     w_next = HOLD;
                HOLD:    w_next = wb_stb_i ? HOLD : IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (wb_rst_i)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk_sys) begin
        if (wb_rst_i) begin
            r_pend <= '0;
            r_prev <= '0;
            r_oh   <= '0;
            r_iack <= '0;
            r_last <= '0;
            r_dat  <= '0;
            r_ack  <= 1'b0;
            r_irq  <= 1'b0;
        end else if (ce) begin
            r_prev <= ireq;
            r_pend <= w_pend;
            r_irq  <= |(w_elig & ~w_excl);
            r_iack <= w_go ? w_oh : '0;
            if (w_go) begin
                r_oh  <= w_oh;
                r_ack <= 1'b1;
                r_dat <= w_vld ? ivec[16*int'(w_idx) +: 16] : SPUR_VEC;
                if (w_vld)
                    r_last <= w_idx;
            end else if (r_state == HOLD && !wb_stb_i) begin
                r_ack <= 1'b0;
                r_dat <= '0;
            end
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat;
    assign wb_irq_o = r_irq;
    assign iack     = r_iack;
endmodule

// File: tb/tb_vic_prio.sv
// tb_vic_prio: directed checks of vic_prio, fixed-priority edge and round-robin level instances
module tb_vic_prio;
    logic        clk_sys = 1'b0;
    logic        rst = 1'b1, ce = 1'b1, slow = 1'b0;
    logic [1:0]  ireq2 = '0, imask2 = '0, iack2;
    logic [3:0]  ireq4 = '0, imask4 = '0, iack4;
    logic        stb2 = 1'b0, stb4 = 1'b0;
    logic        ack2, ack4, irq2, irq4;
    logic [15:0] dat2, dat4;
    logic [31:0] ivec2 = {16'o000060, 16'o000274};
    logic [63:0] ivec4 = {16'o000403, 16'o000402, 16'o000401, 16'o000400};
    int n_chk = 0, n_err = 0;

    always #5 clk_sys = ~clk_sys;

    vic_prio u_dut (
        .clk_sys(clk_sys), .wb_rst_i(rst), .ce(ce), .ireq(ireq2), .imask(imask2),
        .ivec(ivec2), .wb_stb_i(stb2), .wb_ack_o(ack2), .wb_dat_o(dat2),
        .wb_irq_o(irq2), .iack(iack2)
    );

    vic_prio #(.N(4), .EDGE(4'b0000), .RR(1), .SPUR_VEC(16'o000777)) u_rr (
        .clk_sys(clk_sys), .wb_rst_i(rst), .ce(ce), .ireq(ireq4), .imask(imask4),
        .ivec(ivec4), .wb_stb_i(stb4), .wb_ack_o(ack4), .wb_dat_o(dat4),
        .wb_irq_o(irq4), .iack(iack4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one ce cycle; in slow mode ce is high only every 24th clock
    task automatic tick();
        if (slow) begin
            ce = 1'b0;
            repeat (23) @(negedge clk_sys);
        end
        ce = 1'b1;
        @(negedge clk_sys);
    endtask

    task automatic strobe(input bit sel, input logic [15:0] dat, input logic [3:0] oh,
                          input logic irq, input string tag);
        if (sel) stb4 = 1'b1; else stb2 = 1'b1;
        tick();
        check({tag, ".ack"},  32'(sel ? ack4 : ack2), 32'd1);
        check({tag, ".dat"},  32'(sel ? dat4 : dat2), 32'(dat));
        check({tag, ".iack"}, sel ? 32'(iack4) : 32'(iack2), 32'(oh));
        check({tag, ".irq"},  32'(sel ? irq4 : irq2), 32'(irq));
        tick();
        check({tag, ".hold"}, sel ? 32'({ack4, dat4, iack4}) : 32'({ack2, dat2, iack2}),
              sel ? 32'({1'b1, dat, 4'b0}) : 32'({1'b1, dat, 2'b0}));
        if (sel) stb4 = 1'b0; else stb2 = 1'b0;
        tick();
        check({tag, ".end"}, sel ? 32'({ack4, dat4}) : 32'({ack2, dat2}), 32'd0);
    endtask

    initial begin
        tick();
        tick();
        check("rst.out", 32'({ack2, dat2, irq2, iack2}), 32'd0);
        check("rst.rr", 32'({ack4, dat4, irq4, iack4}), 32'd0);
        rst = 1'b0;

        // single edge on channel 1
        ireq2 = 2'b10;
        tick();
        check("e1.irq0", 32'(irq2), 32'd0);
        ireq2 = 2'b00;
        tick();
        check("e1.irq1", 32'(irq2), 32'd1);
        strobe(1'b0, 16'o000060, 4'b0010, 1'b0, "e1");

        // simultaneous edges, fixed priority
        ireq2 = 2'b11;
        tick();
        ireq2 = 2'b00;
        tick();
        check("e2.irq", 32'(irq2), 32'd1);
        strobe(1'b0, 16'o000060, 4'b0010, 1'b1, "e2a");
        strobe(1'b0, 16'o000274, 4'b0001, 1'b0, "e2b");
        check("e2.irqoff", 32'(irq2), 32'd0);

        // masked edge stays pending until unmasked
        imask2 = 2'b01;
        ireq2 = 2'b01;
        tick();
        ireq2 = 2'b00;
        tick();
        tick();
        check("m.irq0", 32'(irq2), 32'd0);
        imask2 = 2'b00;
        tick();
        check("m.irq1", 32'(irq2), 32'd1);
        strobe(1'b0, 16'o000274, 4'b0001, 1'b0, "m");

        // nothing pending
        strobe(1'b0, 16'o000000, 4'b0000, 1'b0, "sp");

        // new edge in the same cycle as the clear keeps pending
        ireq2 = 2'b10;
        tick();
        ireq2 = 2'b00;
        tick();
        ireq2 = 2'b10;
        strobe(1'b0, 16'o000060, 4'b0010, 1'b0, "sw1");
        ireq2 = 2'b00;
        tick();
        check("sw.irq", 32'(irq2), 32'd1);
        strobe(1'b0, 16'o000060, 4'b0010, 1'b0, "sw2");

        // round-robin over level channels
        strobe(1'b1, 16'o000777, 4'b0000, 1'b0, "rsp");
        ireq4 = 4'b1111;
        tick();
        tick();
        check("rr.irq", 32'(irq4), 32'd1);
        strobe(1'b1, 16'o000403, 4'b1000, 1'b1, "rr3");
        strobe(1'b1, 16'o000402, 4'b0100, 1'b1, "rr2");
        strobe(1'b1, 16'o000401, 4'b0010, 1'b1, "rr1");
        strobe(1'b1, 16'o000400, 4'b0001, 1'b1, "rr0");
        strobe(1'b1, 16'o000403, 4'b1000, 1'b1, "rr3b");
        ireq4 = 4'b0000;

        // slow ce, reset during HOLD
        slow = 1'b1;
        ireq2 = 2'b10;
        tick();
        ireq2 = 2'b00;
        tick();
        tick();
        check("sl.irq", 32'(irq2), 32'd1);
        stb2 = 1'b1;
        tick();
        check("sl.ack", 32'({ack2, dat2, iack2}), 32'({1'b1, 16'o000060, 2'b10}));
        tick();
        check("sl.hold", 32'({ack2, iack2}), 32'({1'b1, 2'b00}));
        stb2 = 1'b0;
        ce = 1'b0;
        repeat (5) @(negedge clk_sys);
        check("sl.cehold", 32'({ack2, dat2}), 32'({1'b1, 16'o000060}));
        rst = 1'b1;
        @(negedge clk_sys);
        check("sl.rst", 32'({ack2, dat2, irq2, iack2}), 32'd0);
        rst = 1'b0;
        tick();
        tick();
        check("sl.noiack", 32'({ack2, iack2}), 32'd0);
        ireq2 = 2'b01;
        tick();
        ireq2 = 2'b00;
        tick();
        tick();
        check("sl.irq2", 32'(irq2), 32'd1);
        strobe(1'b0, 16'o000274, 4'b0001, 1'b0, "sl");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
